// File: rtl/cordic_linear_unit.sv
// Iterative linear-mode CORDIC engine with valid/ready handshakes on both sides.
// Rotation produces y0 + x0*z0 and vectoring produces z0 + y0/x0, one iteration per clock.
module cordic_linear_unit #(
    parameter int  INT_SIZE   = 8,
    parameter int  FLOAT_SIZE = 24,
    parameter int  ITER       = 24,
    localparam int W          = INT_SIZE + FLOAT_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic [W-1:0] z_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic [W-1:0] z_out,
    output logic         err_out,
    output logic         busy
);

    localparam int CW = $clog2(ITER + 1);
    localparam logic [W-1:0] ONE = {{(INT_SIZE-1){1'b0}}, 1'b1, {FLOAT_SIZE{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Range and divide-by-zero check, done two bits wider so negation and doubling cannot overflow.
    function automatic logic calc_err(input logic mode, input logic [W-1:0] x,
                                      input logic [W-1:0] y, input logic [W-1:0] z);
        logic signed [W+1:0] xe;
        logic signed [W+1:0] ye;
        logic signed [W+1:0] ze;
        logic signed [W+1:0] ax;
        logic signed [W+1:0] ay;
        logic signed [W+1:0] two;
        xe  = {{2{x[W-1]}}, x};
        ye  = {{2{y[W-1]}}, y};
        ze  = {{2{z[W-1]}}, z};
        ax  = xe[W+1] ? -xe : xe;
        ay  = ye[W+1] ? -ye : ye;
        two = {{INT_SIZE{1'b0}}, 2'b10, {FLOAT_SIZE{1'b0}}};
        if (mode) begin
            calc_err = (x == {W{1'b0}}) || (ay >= (ax + ax));
        end else begin
            calc_err = (ze >= two) || (ze < -two);
        end
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic signed [W-1:0]  x_r;
    logic signed [W-1:0]  y_r;
    logic signed [W-1:0]  z_r;
    logic signed [W-1:0]  x_s;
    logic signed [W-1:0]  y_s;
    logic signed [W-1:0]  z_s;
    logic                 mode_r;
    logic                 mode_s;
    logic                 err_r;
    logic                 err_s;
    logic                 bypass_r;
    logic                 bypass_s;
    logic [CW-1:0]        cnt_r;
    logic [CW-1:0]        cnt_s;
    logic                 out_valid_r;
    logic                 out_valid_s;

    logic signed [W-1:0]  xs_s;
    logic signed [W-1:0]  one_s;
    logic                 add_dir_s;
    logic signed [W-1:0]  y_iter_s;
    logic signed [W-1:0]  z_iter_s;

    // One CORDIC micro-rotation on the current register contents.
    always_comb begin
        xs_s  = x_r >>> cnt_r;
        one_s = ONE >> cnt_r;
        if (mode_r) begin
            add_dir_s = (y_r[W-1] != x_r[W-1]);
        end else begin
            add_dir_s = ~z_r[W-1];
        end
        if (add_dir_s) begin
            y_iter_s = y_r + xs_s;
            z_iter_s = z_r - one_s;
        end else begin
            y_iter_s = y_r - xs_s;
            z_iter_s = z_r + one_s;
        end
    end

    // Controller next-state and datapath load/update selection.
    always_comb begin
        state_s     = state_r;
        x_s         = x_r;
        y_s         = y_r;
        z_s         = z_r;
        mode_s      = mode_r;
        err_s       = err_r;
        bypass_s    = bypass_r;
        cnt_s       = cnt_r;
        out_valid_s = out_valid_r;
        if (flush) begin
            state_s     = IDLE;
            out_valid_s = 1'b0;
            err_s       = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        x_s      = x_in;
                        y_s      = y_in;
                        z_s      = z_in;
                        mode_s   = in_mode;
                        err_s    = calc_err(in_mode, x_in, y_in, z_in);
                        bypass_s = in_mode && (x_in == {W{1'b0}});
                        cnt_s    = {CW{1'b0}};
                        state_s  = RUN;
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    // A divide by zero skips the iterations and presents the operands unchanged.
                    if (bypass_r) begin
                        bypass_s    = 1'b0;
                        state_s     = DONE;
                        out_valid_s = 1'b1;
                    end else begin
                        y_s   = y_iter_s;
                        z_s   = z_iter_s;
                        cnt_s = cnt_r + CW'(1);
                        if (cnt_r == CW'(ITER - 1)) begin
                            state_s     = DONE;
                            out_valid_s = 1'b1;
                        end else begin
                            state_s = RUN;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_s     = IDLE;
                        out_valid_s = 1'b0;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: begin
                    state_s     = IDLE;
                    out_valid_s = 1'b0;
                end
            endcase
        end
    end

    // State, counter and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            x_r         <= {W{1'b0}};
            y_r         <= {W{1'b0}};
            z_r         <= {W{1'b0}};
            mode_r      <= 1'b0;
            err_r       <= 1'b0;
            bypass_r    <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            y_r         <= y_s;
            z_r         <= z_s;
            mode_r      <= mode_s;
            err_r       <= err_s;
            bypass_r    <= bypass_s;
            cnt_r       <= cnt_s;
            out_valid_r <= out_valid_s;
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign out_valid = out_valid_r;
    assign err_out   = err_r;
    assign x_out     = x_r;
    assign y_out     = y_r;
    assign z_out     = z_r;

endmodule

// File: tb/tb_cordic_linear_unit.sv
// Self-checking bench for cordic_linear_unit: directed table, random vectors against
// an arithmetic reference model, and hand sequences for backpressure, flush and reset.
module tb_cordic_linear_unit;

    localparam int INT_SIZE   = 8;
    localparam int FLOAT_SIZE = 24;
    localparam int ITER       = 24;
    localparam int W          = INT_SIZE + FLOAT_SIZE;
    localparam int ONE        = 1 << FLOAT_SIZE;
    localparam int NTBL       = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [W-1:0] x_in;
    logic [W-1:0] y_in;
    logic [W-1:0] z_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] x_out;
    logic [W-1:0] y_out;
    logic [W-1:0] z_out;
    logic         err_out;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cordic_linear_unit #(
        .INT_SIZE  (INT_SIZE),
        .FLOAT_SIZE(FLOAT_SIZE),
        .ITER      (ITER)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .x_in     (x_in),
        .y_in     (y_in),
        .z_in     (z_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out    (x_out),
        .y_out    (y_out),
        .z_out    (z_out),
        .err_out  (err_out),
        .busy     (busy)
    );

    typedef struct {
        logic        mode;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_y;
        int          y_tol;
        logic [31:0] exp_z;
        int          z_tol;
    } vec_t;

    vec_t tbl [NTBL];

    // Reference: the CORDIC recurrence written as a plain integer loop, plus the error rules.
    function automatic void ref_model(input logic mode, input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z, output logic [31:0] ym,
                                      output logic [31:0] zm, output logic em, output int lat);
        longint xl, yl, zl, ax, ay;
        int xi, yi, zi, xs, one;
        xl = longint'($signed(x));
        yl = longint'($signed(y));
        zl = longint'($signed(z));
        ax = (xl < 0) ? -xl : xl;
        ay = (yl < 0) ? -yl : yl;
        if (mode) em = (xl == 0) || (ay >= 2 * ax);
        else      em = (zl >= 2 * longint'(ONE)) || (zl < -2 * longint'(ONE));
        xi = $signed(x);
        yi = $signed(y);
        zi = $signed(z);
        if (mode && xl == 0) begin
            ym  = y;
            zm  = z;
            lat = 1;
        end else begin
            for (int i = 0; i < ITER; i++) begin
                xs  = xi >>> i;
                one = ONE >>> i;
                if (mode ? ((yi < 0) != (xi < 0)) : (zi >= 0)) begin
                    yi = yi + xs;
                    zi = zi - one;
                end else begin
                    yi = yi - xs;
                    zi = zi + one;
                end
            end
            ym  = yi;
            zm  = zi;
            lat = ITER;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endtask

    task automatic chk_tol(input string nm, input logic [31:0] act, input logic [31:0] want,
                           input int tol);
        int d;
        if (tol >= 0) begin
            d = $signed(act) - $signed(want);
            vectors++;
            if (d > tol || d < -tol) begin
                miscompares++;
                $display("FAIL %s: got %h, expected %h +/- %0d LSB", nm, act, want, tol);
            end
        end
    endtask

    task automatic drive(input logic m, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z);
        in_valid = 1'b1;
        in_mode  = m;
        x_in     = x;
        y_in     = y;
        z_in     = z;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Full transaction from IDLE: accept, wait, compare against the model, then drain.
    task automatic run_vec(input string nm, input logic m, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] z, output logic [31:0] yo,
                           output logic [31:0] zo, output logic eo, output int lat);
        logic [31:0] ym, zm;
        logic        em;
        int          lm;
        ref_model(m, x, y, z, ym, zm, em, lm);
        drive(m, x, y, z);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        yo = y_out;
        zo = z_out;
        eo = err_out;
        chk({nm, ".lat"}, lat, lm);
        chk({nm, ".x"}, x_out, x);
        chk({nm, ".y"}, y_out, ym);
        chk({nm, ".z"}, z_out, zm);
        chk({nm, ".err"}, {31'b0, err_out}, {31'b0, em});
        consume();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] yo, zo, x, y, z, ym, zm;
        logic        eo, m, em, seen;
        int          lat, lm;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
        x_in = '0; y_in = '0; z_in = '0; out_ready = 1'b0;

        tbl[0]  = '{1'b0, 32'h01800000, 32'h00000000, 32'h00800000, 1'b0, 24, 32'h00C00000, 28, 32'h00000000, 2};
        tbl[1]  = '{1'b1, 32'h02000000, 32'h01000000, 32'h00000000, 1'b0, 24, 32'h00000000, -1, 32'h00800000, 28};
        tbl[2]  = '{1'b1, 32'hFE000000, 32'h01000000, 32'h00000000, 1'b0, 24, 32'h00000000, -1, 32'hFF800000, 28};
        tbl[3]  = '{1'b1, 32'h00000000, 32'h01000000, 32'h00123456, 1'b1, 1,  32'h01000000, 0,  32'h00123456, 0};
        tbl[4]  = '{1'b0, 32'h01000000, 32'h00000000, 32'h02000000, 1'b1, 24, 32'h00000000, -1, 32'h00000000, -1};
        tbl[5]  = '{1'b0, 32'h00400000, 32'h00000000, 32'hFE000000, 1'b0, 24, 32'h00000000, -1, 32'h00000000, -1};
        tbl[6]  = '{1'b0, 32'h00400000, 32'h00000000, 32'hFDFFFFFF, 1'b1, 24, 32'h00000000, -1, 32'h00000000, -1};
        tbl[7]  = '{1'b1, 32'h01000000, 32'h02000000, 32'h00000000, 1'b1, 24, 32'h00000000, -1, 32'h00000000, -1};
        tbl[8]  = '{1'b1, 32'h01000000, 32'h01FFFFFF, 32'h00000000, 1'b0, 24, 32'h00000000, -1, 32'h01FFFFFF, 28};
        tbl[9]  = '{1'b1, 32'hFF000000, 32'hFE000000, 32'h00000000, 1'b1, 24, 32'h00000000, -1, 32'h00000000, -1};
        tbl[10] = '{1'b0, 32'h00800000, 32'h00100000, 32'hFF400000, 1'b0, 24, 32'hFFB00000, 28, 32'h00000000, 2};

        // Reset state
        #12;
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.err", {31'b0, err_out}, 32'd0);
        chk("rst.x", x_out, 32'd0);
        chk("rst.y", y_out, 32'd0);
        chk("rst.z", z_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.in_ready", {31'b0, in_ready}, 32'd1);

        // Directed table
        for (int i = 0; i < NTBL; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].x, tbl[i].y, tbl[i].z,
                    yo, zo, eo, lat);
            chk($sformatf("tbl%0d.err_c", i), {31'b0, eo}, {31'b0, tbl[i].exp_err});
            chk($sformatf("tbl%0d.lat_c", i), lat, tbl[i].exp_lat);
            chk_tol($sformatf("tbl%0d.y_tol", i), yo, tbl[i].exp_y, tbl[i].y_tol);
            chk_tol($sformatf("tbl%0d.z_tol", i), zo, tbl[i].exp_z, tbl[i].z_tol);
        end

        // Random vectors against the model
        for (int n = 0; n < 40; n++) begin
            m = 1'($urandom_range(0, 1));
            x = $urandom;
            y = $urandom;
            z = $urandom;
            if (n % 2 == 0) begin
                x = $signed(x) >>> 6;
                y = $signed(y) >>> 7;
                z = $signed(z) >>> 6;
            end
            if (m && $urandom_range(0, 7) == 0) x = '0;
            run_vec($sformatf("rnd%0d", n), m, x, y, z, yo, zo, eo, lat);
        end

        // Backpressure: result held 10 cycles while a new request waits on in_valid
        ref_model(1'b0, 32'h01800000, 32'h00100000, 32'h00400000, ym, zm, em, lm);
        drive(1'b0, 32'h01800000, 32'h00100000, 32'h00400000);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        chk("bp.lat", lat, 32'd24);
        drive(1'b1, 32'h02000000, 32'h00C00000, 32'h00000000);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp%0d.out_valid", c), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp%0d.in_ready", c), {31'b0, in_ready}, 32'd0);
            chk($sformatf("bp%0d.busy", c), {31'b0, busy}, 32'd1);
            chk($sformatf("bp%0d.y", c), y_out, ym);
            chk($sformatf("bp%0d.z", c), z_out, zm);
            chk($sformatf("bp%0d.x", c), x_out, 32'h01800000);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.idle_out_valid", {31'b0, out_valid}, 32'd0);
        chk("bp.idle_in_ready", {31'b0, in_ready}, 32'd1);
        chk("bp.idle_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.b2b_busy", {31'b0, busy}, 32'd1);
        chk("bp.b2b_in_ready", {31'b0, in_ready}, 32'd0);
        ref_model(1'b1, 32'h02000000, 32'h00C00000, 32'h00000000, ym, zm, em, lm);
        wait_done(lat);
        chk("bp.b2b_lat", lat, lm);
        chk("bp.b2b_z", z_out, zm);
        chk_tol("bp.b2b_z_tol", z_out, 32'h00600000, 28);
        consume();

        // Flush at iteration 10, in_valid ignored alongside it
        drive(1'b0, 32'h00C00000, 32'h00000000, 32'h00600000);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl.busy", {31'b0, busy}, 32'd0);
        chk("fl.in_ready", {31'b0, in_ready}, 32'd1);
        chk("fl.out_valid", {31'b0, out_valid}, 32'd0);
        flush = 1'b1;
        drive(1'b0, 32'h00C00000, 32'h00000000, 32'h00600000);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl.idle_busy", {31'b0, busy}, 32'd0);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("fl.no_out_valid", {31'b0, seen}, 32'd0);
        run_vec("fl.after", 1'b0, 32'h00C00000, 32'h00000000, 32'h00600000, yo, zo, eo, lat);
        chk_tol("fl.after_y_tol", yo, 32'h00480000, 28);

        // Flush while an error result is waiting in DONE
        drive(1'b0, 32'h01000000, 32'h00000000, 32'h02000000);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        chk("fd.err", {31'b0, err_out}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("fd.err_clr", {31'b0, err_out}, 32'd0);
        chk("fd.out_valid", {31'b0, out_valid}, 32'd0);
        chk("fd.busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset mid-RUN
        drive(1'b1, 32'h01000000, 32'h00800000, 32'h00100000);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("ar.out_valid", {31'b0, out_valid}, 32'd0);
        chk("ar.busy", {31'b0, busy}, 32'd0);
        chk("ar.x", x_out, 32'd0);
        chk("ar.y", y_out, 32'd0);
        chk("ar.z", z_out, 32'd0);
        chk("ar.err", {31'b0, err_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ar.in_ready", {31'b0, in_ready}, 32'd1);
        run_vec("ar.after", 1'b1, 32'h01000000, 32'h00800000, 32'h00100000, yo, zo, eo, lat);
        chk_tol("ar.after_z_tol", zo, 32'h00900000, 28);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
